// File: rtl/mdu_unit_pkg.sv
// Shared types for the multiply/divide unit: op codes and FSM states.
package mdu_unit_pkg;

  typedef enum logic [2:0] {
    MduNone  = 3'd0,
    MduMult  = 3'd1,
    MduMultu = 3'd2,
    MduDiv   = 3'd3,
    MduDivu  = 3'd4,
    MduMthi  = 3'd5,
    MduMtlo  = 3'd6,
    MduRsvd  = 3'd7
  } mdu_op_e;

  typedef enum logic [0:0] {
    StIdle = 1'b0,
    StRun  = 1'b1
  } mdu_state_e;

  localparam int unsigned DataW = 32;

endpackage

// File: rtl/mdu_unit_if.sv
// Issue/result bundle between the E-stage datapath and the MDU.
interface mdu_unit_if;
  import mdu_unit_pkg::*;

  logic [DataW-1:0] A;
  logic [DataW-1:0] B;
  logic [2:0]       MDUOp;
  logic             start;
  logic             flush;
  logic             busy;
  logic [DataW-1:0] HI;
  logic [DataW-1:0] LO;

  modport master (
    output A, B, MDUOp, start, flush,
    input  busy, HI, LO
  );

  modport slave (
    input  A, B, MDUOp, start, flush,
    output busy, HI, LO
  );

endinterface

// File: rtl/mdu_unit.sv
// Multi-cycle multiply/divide unit owning HI/LO. The result is computed on the start
// edge and held back for a fixed number of busy cycles before it is committed.
module mdu_unit
  import mdu_unit_pkg::*;
#(
  parameter int unsigned MULT_CYCLES = 5,
  parameter int unsigned DIV_CYCLES  = 10
) (
  input  logic     clk,
  input  logic     reset,
  mdu_unit_if.slave bus
);

  localparam int unsigned MaxCycles = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
  localparam int unsigned CntW      = $clog2(MaxCycles + 1);

  mdu_state_e       state_q, state_d;
  logic [CntW-1:0]  cnt_q, cnt_d;
  logic [DataW-1:0] hi_q, hi_d, lo_q, lo_d;
  logic [DataW-1:0] res_hi_q, res_hi_d, res_lo_q, res_lo_d;
  logic             res_wr_q, res_wr_d;

  logic [63:0]        prod;
  logic [63:0]        prod_s;
  logic [DataW-1:0]   divisor;
  logic [DataW-1:0]   quot_u, rem_u;
  logic signed [DataW-1:0] a_s, d_s, quot_s, rem_s;
  logic               div_ovf;
  mdu_op_e            op;

  assign op = mdu_op_e'(bus.MDUOp);

  // Low 64 bits of the sign-extended product equal the signed product.
  assign prod    = {32'd0, bus.A} * {32'd0, bus.B};
  assign prod_s  = {{32{bus.A[31]}}, bus.A} * {{32{bus.B[31]}}, bus.B};
  // Substitute 1 for a zero divisor; that result is never committed.
  assign divisor = (bus.B == '0) ? 32'd1 : bus.B;
  assign quot_u  = bus.A / divisor;
  assign rem_u   = bus.A % divisor;
  assign a_s     = $signed(bus.A);
  assign d_s     = $signed(divisor);
  assign div_ovf = (bus.A == 32'h8000_0000) && (bus.B == 32'hFFFF_FFFF);

  always_comb begin
    quot_s = a_s / d_s;
    rem_s  = a_s % d_s;
    if (div_ovf) begin
      quot_s = a_s;
      rem_s  = '0;
    end
  end

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    hi_d     = hi_q;
    lo_d     = lo_q;
    res_hi_d = res_hi_q;
    res_lo_d = res_lo_q;
    res_wr_d = res_wr_q;
    unique case (state_q)
      StIdle: begin
        if (bus.start && !bus.flush) begin
          unique case (op)
            MduMult, MduMultu: begin
              state_d  = StRun;
              cnt_d    = CntW'(MULT_CYCLES - 1);
              res_wr_d = 1'b1;
              {res_hi_d, res_lo_d} = (op == MduMult) ? prod_s : prod;
            end
            MduDiv, MduDivu: begin
              state_d  = StRun;
              cnt_d    = CntW'(DIV_CYCLES - 1);
              res_wr_d = (bus.B != '0);
              res_lo_d = (op == MduDiv) ? quot_s : quot_u;
              res_hi_d = (op == MduDiv) ? rem_s : rem_u;
            end
            MduMthi: hi_d = bus.A;
            MduMtlo: lo_d = bus.A;
            default: ;
          endcase
        end
      end
      StRun: begin
        if (bus.flush) begin
          state_d = StIdle;
          cnt_d   = '0;
        end else if (cnt_q == '0) begin
          state_d = StIdle;
          if (res_wr_q) begin
            hi_d = res_hi_q;
            lo_d = res_lo_q;
          end
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q  <= StIdle;
      cnt_q    <= '0;
      hi_q     <= '0;
      lo_q     <= '0;
      res_hi_q <= '0;
      res_lo_q <= '0;
      res_wr_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      hi_q     <= hi_d;
      lo_q     <= lo_d;
      res_hi_q <= res_hi_d;
      res_lo_q <= res_lo_d;
      res_wr_q <= res_wr_d;
    end
  end

  assign bus.busy = (state_q == StRun);
  assign bus.HI   = hi_q;
  assign bus.LO   = lo_q;

endmodule
